// File: rtl/kmac_pkg.sv
// Shared types and widths for the Karatsuba multiply-accumulate datapath.
package kmac_pkg;

  localparam int unsigned MUL_W    = 32;
  localparam int unsigned PROD_W   = 64;
  localparam int unsigned PIPE_LAT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/karatsuba_mac.sv
// Combinational 32x32 -> 64 unsigned multiplier using one level of Karatsuba
// splitting: three half-width products instead of four.
module karatsuba_mac
  import kmac_pkg::*;
(
  input  logic [MUL_W-1:0]  a_i,
  input  logic [MUL_W-1:0]  b_i,
  output logic [PROD_W-1:0] prod_c
);

  localparam int unsigned H_W  = MUL_W / 2;
  localparam int unsigned S_W  = H_W + 1;
  localparam int unsigned M_W  = 2 * S_W;

  logic [H_W-1:0]   a_hi, a_lo, b_hi, b_lo;
  logic [MUL_W-1:0] z2, z0;
  logic [S_W-1:0]   sum_a, sum_b;
  logic [M_W-1:0]   z_mid, z1;

  // Split halves, form the three partial products and recombine.
  always_comb begin
    a_hi   = a_i[MUL_W-1:H_W];
    a_lo   = a_i[H_W-1:0];
    b_hi   = b_i[MUL_W-1:H_W];
    b_lo   = b_i[H_W-1:0];
    z2     = MUL_W'(a_hi) * MUL_W'(b_hi);
    z0     = MUL_W'(a_lo) * MUL_W'(b_lo);
    sum_a  = S_W'(a_hi) + S_W'(a_lo);
    sum_b  = S_W'(b_hi) + S_W'(b_lo);
    z_mid  = M_W'(sum_a) * M_W'(sum_b);
    // Cross term a_hi*b_lo + a_lo*b_hi; never negative, fits in M_W bits.
    z1     = z_mid - M_W'(z2) - M_W'(z0);
    prod_c = (PROD_W'(z2) << MUL_W) + (PROD_W'(z1) << H_W) + PROD_W'(z0);
  end

endmodule

// File: rtl/karatsuba_dot_ctrl.sv
// Dot-product sequencer: accepts a job with a term count, streams operand
// pairs through a two-stage multiply pipeline and accumulates the products.
module karatsuba_dot_ctrl
  import kmac_pkg::*;
#(
  parameter int unsigned ACC_W = 72,
  parameter int unsigned LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MUL_W-1:0]  a_in,
  input  logic [MUL_W-1:0]  b_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [MUL_W-1:0]   op_a_q, op_b_q;
  logic               v1_q, v2_q;
  logic [PROD_W-1:0]  prod_q;
  logic [PROD_W-1:0]  prod_c;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, in_ready_q, out_valid_q;
  logic               accept_c;
  logic [ACC_W:0]     sum_c;

  assign accept_c  = in_valid && in_ready_q;
  assign busy      = busy_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;

  karatsuba_mac u_mac (
    .a_i    (op_a_q),
    .b_i    (op_b_q),
    .prod_c (prod_c)
  );

  // Next-state, term counter and accumulator update.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    sum_c       = {1'b0, acc_q} + (ACC_W+1)'(prod_q);

    if (v2_q) begin
      acc_d = sum_c[ACC_W-1:0];
      if (sum_c[ACC_W]) begin
        ovf_d = 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (len != '0) begin
            remaining_d = len;
            state_d     = ST_RUN;
          end else begin
            state_d     = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (accept_c) begin
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      // The last product is in stage 2 once nothing is left in stage 1.
      ST_DRAIN: begin
        if (v2_q && !v1_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller state, counter, accumulator and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      busy_q      <= (state_d != ST_IDLE);
      in_ready_q  <= (state_d == ST_RUN) && (remaining_d != '0);
      out_valid_q <= (state_d == ST_DONE);
    end
  end

  // Free-running two-stage operand/product pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q <= '0;
      op_b_q <= '0;
      v1_q   <= 1'b0;
      prod_q <= '0;
      v2_q   <= 1'b0;
    end else begin
      if (accept_c) begin
        op_a_q <= a_in;
        op_b_q <= b_in;
      end
      v1_q   <= accept_c;
      prod_q <= prod_c;
      v2_q   <= v1_q;
    end
  end

endmodule

// File: tb/tb_karatsuba_dot_ctrl.sv
// Directed bench for karatsuba_dot_ctrl: a default 72-bit instance and a
// 64-bit instance share one stimulus stream.
module tb_karatsuba_dot_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        out_ready = 1'b0;

  logic        busy, in_ready, out_valid, ovf;
  logic [71:0] acc_out;
  logic        busy64, in_ready64, out_valid64, ovf64;
  logic [63:0] acc_out64;

  int errors = 0;
  int checks = 0;

  karatsuba_dot_ctrl #(.ACC_W(72), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out), .ovf(ovf)
  );

  karatsuba_dot_ctrl #(.ACC_W(64), .LEN_W(8)) dut64 (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy64),
    .in_valid(in_valid), .in_ready(in_ready64), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid64), .out_ready(out_ready), .acc_out(acc_out64), .ovf(ovf64)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
    len   = '0;
  endtask

  // Present one pair and hold it until the handshake edge has passed.
  task automatic send_beat(input logic [31:0] a, input logic [31:0] b);
    logic rdy;
    int   n;
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    n = 0;
    do begin
      rdy = in_ready;
      tick();
      n++;
    end while (!rdy && n < 20);
    in_valid = 1'b0;
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL beat_accept: in_ready=%0b after %0d cycles, required 1", rdy, n);
    end
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL result_wait: out_valid=%0b after %0d cycles, required 1", out_valid, n);
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if ({busy, in_ready, out_valid, ovf} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: busy/in_ready/out_valid/ovf=%b, required 0000",
               {busy, in_ready, out_valid, ovf});
    end
    checks++;
    if (acc_out !== 72'd0) begin
      errors++;
      $display("FAIL reset_acc: acc_out=%0d, required 0", acc_out);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_in_ready: got %0b, required 0", in_ready);
    end
  endtask

  task automatic test_basic();
    do_start(8'd2);
    send_beat(32'd12345678, 32'd87654321);
    send_beat(32'd11111111, 32'd22222222);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_lat0: out_valid=%0b at handshake edge, required 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_lat1: out_valid=%0b one edge after, required 0", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_lat2: out_valid=%0b two edges after, required 1", out_valid);
    end
    checks++;
    if (acc_out !== 72'd1329065597683280) begin
      errors++;
      $display("FAIL basic_acc: acc_out=%0d, required 1329065597683280", acc_out);
    end
    checks++;
    if (ovf !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_flags: ovf=%0b busy=%0b, required ovf=0 busy=1", ovf, busy);
    end
    take_result();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_release: out_valid=%0b busy=%0b, required 0 0", out_valid, busy);
    end
    checks++;
    if (acc_out !== 72'd1329065597683280) begin
      errors++;
      $display("FAIL basic_hold: acc_out=%0d in idle, required 1329065597683280", acc_out);
    end
  endtask

  task automatic test_empty();
    logic saw_ready;
    saw_ready = 1'b0;
    do_start(8'd0);
    saw_ready = saw_ready | in_ready;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL empty_done: out_valid=%0b one cycle after start, required 1", out_valid);
    end
    checks++;
    if (acc_out !== 72'd0) begin
      errors++;
      $display("FAIL empty_acc: acc_out=%0d, required 0", acc_out);
    end
    take_result();
    saw_ready = saw_ready | in_ready;
    checks++;
    if (saw_ready !== 1'b0) begin
      errors++;
      $display("FAIL empty_in_ready: in_ready seen=%0b, required 0", saw_ready);
    end
  endtask

  task automatic test_bubbles();
    logic [31:0] av [3] = '{32'd1, 32'd3, 32'd5};
    logic [31:0] bv [3] = '{32'd2, 32'd4, 32'd6};
    do_start(8'd3);
    for (int i = 0; i < 3; i++) begin
      send_beat(av[i], bv[i]);
      if (i < 2) repeat (2) tick();
    end
    wait_result();
    checks++;
    if (acc_out !== 72'd44) begin
      errors++;
      $display("FAIL bubble_acc: acc_out=%0d, required 44", acc_out);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || acc_out !== 72'd44) begin
        errors++;
        $display("FAIL backpressure_c%0d: out_valid=%0b busy=%0b acc_out=%0d, required 1 1 44",
                 i, out_valid, busy, acc_out);
      end
    end
    take_result();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: busy=%0b, required 0", busy);
    end
  endtask

  task automatic test_overflow();
    do_start(8'd2);
    send_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_result();
    checks++;
    if (acc_out64 !== 64'hFFFF_FFFC_0000_0002 || ovf64 !== 1'b1) begin
      errors++;
      $display("FAIL ovf64: acc_out=%h ovf=%0b, required fffffffc00000002 1", acc_out64, ovf64);
    end
    checks++;
    if (acc_out !== 72'h1_FFFF_FFFC_0000_0002 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf72: acc_out=%h ovf=%0b, required 01fffffffc00000002 0", acc_out, ovf);
    end
    take_result();
    checks++;
    if (ovf64 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky_idle: ovf=%0b, required 1", ovf64);
    end
    do_start(8'd1);
    checks++;
    if (ovf64 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%0b after next start, required 0", ovf64);
    end
    send_beat(32'd1, 32'd1);
    wait_result();
    checks++;
    if (acc_out64 !== 64'd1 || ovf64 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_next_job: acc_out=%0d ovf=%0b, required 1 0", acc_out64, ovf64);
    end
    take_result();
  endtask

  task automatic test_reset_midjob();
    do_start(8'd4);
    send_beat(32'd100, 32'd200);
    send_beat(32'd300, 32'd400);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, in_ready, out_valid, ovf} !== 4'b0000 || acc_out !== 72'd0) begin
      errors++;
      $display("FAIL midjob_reset: busy/in_ready/out_valid/ovf=%b acc_out=%0d, required 0000 0",
               {busy, in_ready, out_valid, ovf}, acc_out);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midjob_idle: busy=%0b out_valid=%0b, required 0 0", busy, out_valid);
    end
    do_start(8'd1);
    send_beat(32'd7, 32'd9);
    wait_result();
    checks++;
    if (acc_out !== 72'd63) begin
      errors++;
      $display("FAIL after_reset_acc: acc_out=%0d, required 63", acc_out);
    end
    take_result();
  endtask

  task automatic test_start_busy();
    do_start(8'd2);
    send_beat(32'd2, 32'd3);
    do_start(8'd5);
    send_beat(32'd4, 32'd5);
    wait_result();
    checks++;
    if (acc_out !== 72'd26) begin
      errors++;
      $display("FAIL start_busy_acc: acc_out=%0d, required 26", acc_out);
    end
    // Result handshake and a new start in the same DONE cycle.
    start = 1'b1;
    len = 8'd3;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    len = '0;
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_start_drop: busy=%0b out_valid=%0b, required 0 0", busy, out_valid);
    end
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_not_queued: busy=%0b in_ready=%0b, required 0 0", busy, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_bubbles();
    test_overflow();
    test_reset_midjob();
    test_start_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
